rv_iopmp_entry_encoder: RTL and testbench

Programming-side counterpart of the IOPMP entry matcher: converts a byte region (base, length, RWX) into the sequence of IOPMP entry words that the matcher decodes. The sequence uses NAPOT/NA4 decomposition or a TOR pair.
Sits between the configuration front-end and the entry-table write port. It accepts one region per request and streams one entry per beat with valid/ready flow control.
Emitted words use the 66-bit entry address format: {addrh, addr} holds address bits 65:2.

---
 rtl/rv_iopmp_entry_encoder.sv | 205 ++++++++++++++++++++
 tb/tb_rv_iopmp_entry_encoder.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_iopmp_entry_encoder.sv
// Purpose : turns a byte region (base, len, rwx) into IOPMP entry words (NAPOT/NA4 blocks or a TOR pair).
// Latency : first entry beat is valid the cycle after request acceptance; then 1 entry/cycle.
// Backpressure: entry payload holds while entry_ready_i=0; req_ready_o stays low until the last beat is taken.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   req_valid_i/req_ready_o request handshake; req_base_i, req_len_i, req_perm_i {x,w,r}, req_tor_i
//   entry_valid_o/entry_ready_i  entry beat handshake
//   entry_addr_o/entry_addrh_o   entry word (address bits 65:2) split in LEN-bit halves
//   entry_mode_o, entry_perm_o, entry_idx_o, entry_last_o, entry_err_o, entry_err_code_o
//
// Build option: define IOPMP_ENC_NA4_EN for 4-byte granularity (NA4 entries);
// undefined gives 8-byte granularity and NA4 is never produced.

package rv_iopmp_pkg;
    typedef enum logic [1:0] {
        OFF   = 2'd0,
        TOR   = 2'd1,
        NA4   = 2'd2,
        NAPOT = 2'd3
    } mode_t;
endpackage

module rv_iopmp_entry_encoder
    import rv_iopmp_pkg::*;
#(
    parameter int ADDR_WIDTH  = 64,
    parameter int LEN         = 32,
    parameter int MAX_ENTRIES = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [ADDR_WIDTH-1:0] req_base_i,
    input  logic [ADDR_WIDTH-1:0] req_len_i,
    input  logic [2:0]            req_perm_i,
    input  logic                  req_tor_i,
    output logic                  entry_valid_o,
    input  logic                  entry_ready_i,
    output logic [LEN-1:0]        entry_addr_o,
    output logic [LEN-1:0]        entry_addrh_o,
    output mode_t                 entry_mode_o,
    output logic [2:0]            entry_perm_o,
    output logic [7:0]            entry_idx_o,
    output logic                  entry_last_o,
    output logic                  entry_err_o,
    output logic [1:0]            entry_err_code_o
);

`ifdef IOPMP_ENC_NA4_EN
    localparam int GRAN_BITS = 2;
    localparam bit NA4_EN    = 1'b1;
`else
    localparam int GRAN_BITS = 3;
    localparam bit NA4_EN    = 1'b0;
`endif

    localparam logic [7:0]          MAX_IDX = 8'(MAX_ENTRIES);
    localparam logic [ADDR_WIDTH:0] ONE     = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0] FOUR    = (ADDR_WIDTH+1)'(4);

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH:0]   cur_q;      // carry bit lets cur reach 2^ADDR_WIDTH
    logic [ADDR_WIDTH-1:0] rem_q;
    logic [2:0]            perm_q;
    logic                  tor_q;
    logic [7:0]            idx_q;
    logic [1:0]            code_q;     // nonzero: request was rejected, emit one error beat

    // Request validation, evaluated on the raw inputs at acceptance.
    logic [ADDR_WIDTH:0] req_sum;
    logic                req_misaligned;
    logic                req_range_bad;
    logic [1:0]          acc_code;

    always_comb begin
        req_sum        = {1'b0, req_base_i} + {1'b0, req_len_i};
        req_misaligned = (req_base_i[GRAN_BITS-1:0] != '0) || (req_len_i[GRAN_BITS-1:0] != '0);
        // End address may equal 2^ADDR_WIDTH exactly, but not exceed it.
        req_range_bad  = (req_len_i == '0) || (req_sum[ADDR_WIDTH] && (req_sum[ADDR_WIDTH-1:0] != '0));
        if (req_misaligned)     acc_code = 2'd1;
        else if (req_range_bad) acc_code = 2'd2;
        else                    acc_code = 2'd0;
    end

    // Largest naturally aligned block at cur that still fits in rem.
    logic [ADDR_WIDTH:0] align;
    logic [ADDR_WIDTH:0] top;
    logic [ADDR_WIDTH:0] size;

    always_comb begin
        top = '0;
        if (cur_q[ADDR_WIDTH-1:0] == '0) begin
            align = ONE << ADDR_WIDTH;
        end else begin
            // Two's-complement trick isolates the lowest set bit.
            align = {1'b0, cur_q[ADDR_WIDTH-1:0] & (~cur_q[ADDR_WIDTH-1:0] + ADDR_WIDTH'(1))};
        end
        for (int i = 0; i < ADDR_WIDTH; i++) begin
            if (rem_q[i]) top = ONE << i;
        end
        size = (align < top) ? align : top;
    end

    // Beat payload and next state.
    logic [ADDR_WIDTH:0] word;
    logic                beat_last;

    always_comb begin
        state_d          = state_q;
        req_ready_o      = 1'b0;
        entry_valid_o    = 1'b0;
        word             = '0;
        entry_mode_o     = OFF;
        entry_perm_o     = 3'd0;
        entry_idx_o      = 8'd0;
        beat_last        = 1'b0;
        entry_err_o      = 1'b0;
        entry_err_code_o = 2'd0;

        case (state_q)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) state_d = EMIT;
            end
            EMIT: begin
                entry_valid_o = 1'b1;
                entry_idx_o   = idx_q;
                if (code_q != 2'd0) begin
                    entry_err_o      = 1'b1;
                    entry_err_code_o = code_q;
                    beat_last        = 1'b1;
                end else if (tor_q) begin
                    if (idx_q == 8'd0) begin
                        word = cur_q >> 2;
                    end else begin
                        word         = (cur_q + {1'b0, rem_q}) >> 2;
                        entry_mode_o = TOR;
                        entry_perm_o = perm_q;
                        beat_last    = 1'b1;
                    end
                end else if (idx_q == MAX_IDX) begin
                    // Region needs more entries than allowed; the consumer drops the sequence.
                    entry_err_o      = 1'b1;
                    entry_err_code_o = 2'd3;
                    beat_last        = 1'b1;
                end else begin
                    entry_perm_o = perm_q;
                    beat_last    = (rem_q == size[ADDR_WIDTH-1:0]);
                    if (NA4_EN && (size == FOUR)) begin
                        entry_mode_o = NA4;
                        word         = cur_q >> 2;
                    end else begin
                        // NAPOT: trailing ones encode the block size (8B -> no ones).
                        entry_mode_o = NAPOT;
                        word         = (cur_q >> 2) | ((size >> 3) - ONE);
                    end
                end
                if (entry_ready_i && beat_last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign entry_last_o                  = beat_last;
    assign {entry_addrh_o, entry_addr_o} = (2*LEN)'(word);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cur_q   <= '0;
            rem_q   <= '0;
            perm_q  <= 3'd0;
            tor_q   <= 1'b0;
            idx_q   <= 8'd0;
            code_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE) begin
                if (req_valid_i) begin
                    cur_q  <= {1'b0, req_base_i};
                    rem_q  <= req_len_i;
                    perm_q <= req_perm_i;
                    tor_q  <= req_tor_i;
                    idx_q  <= 8'd0;
                    code_q <= acc_code;
                end
            end else if (entry_ready_i) begin
                idx_q <= idx_q + 8'd1;
                // TOR keeps base/len intact so the second beat can form the end address.
                if (!tor_q && (code_q == 2'd0)) begin
                    cur_q <= cur_q + size;
                    rem_q <= rem_q - size[ADDR_WIDTH-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_rv_iopmp_entry_encoder.sv
module tb_rv_iopmp_entry_encoder;

    localparam int MAXE = 16;
`ifdef IOPMP_ENC_NA4_EN
    localparam int G = 4;
`else
    localparam int G = 8;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_base;
    logic [63:0] req_len;
    logic [2:0]  req_perm;
    logic        req_tor;
    logic        entry_valid;
    logic        entry_ready;
    logic [31:0] entry_addr;
    logic [31:0] entry_addrh;
    rv_iopmp_pkg::mode_t entry_mode;
    logic [2:0]  entry_perm;
    logic [7:0]  entry_idx;
    logic        entry_last;
    logic        entry_err;
    logic [1:0]  entry_err_code;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [63:0] word;
        logic [1:0]  mode;
        logic [2:0]  perm;
        logic [7:0]  idx;
        logic        last;
        logic        err;
        logic [1:0]  code;
    } beat_t;

    beat_t exp_q[$];

    rv_iopmp_entry_encoder #(.ADDR_WIDTH(64), .LEN(32), .MAX_ENTRIES(MAXE)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .req_valid_i     (req_valid),
        .req_ready_o     (req_ready),
        .req_base_i      (req_base),
        .req_len_i       (req_len),
        .req_perm_i      (req_perm),
        .req_tor_i       (req_tor),
        .entry_valid_o   (entry_valid),
        .entry_ready_i   (entry_ready),
        .entry_addr_o    (entry_addr),
        .entry_addrh_o   (entry_addrh),
        .entry_mode_o    (entry_mode),
        .entry_perm_o    (entry_perm),
        .entry_idx_o     (entry_idx),
        .entry_last_o    (entry_last),
        .entry_err_o     (entry_err),
        .entry_err_code_o(entry_err_code)
    );

    always #5 clk = ~clk;

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic beat_t observed();
        beat_t b;
        b.word = {entry_addrh, entry_addr};
        b.mode = 2'(entry_mode);
        b.perm = entry_perm;
        b.idx  = entry_idx;
        b.last = entry_last;
        b.err  = entry_err;
        b.code = entry_err_code;
        return b;
    endfunction

    function automatic void push(input logic [63:0] w, input logic [1:0] m, input logic [2:0] p,
                                 input int i, input logic l, input logic e, input logic [1:0] c);
        beat_t b;
        b.word = w; b.mode = m; b.perm = p; b.idx = 8'(i); b.last = l; b.err = e; b.code = c;
        exp_q.push_back(b);
    endfunction

    // Reference: choose the largest power-of-two block aligned at cur that fits in what remains.
    function automatic void model(input logic [63:0] base, input logic [63:0] len,
                                  input logic [2:0] perm, input logic tor);
        logic [64:0] cur, rem, sz, end_addr;
        int n;
        exp_q.delete();
        end_addr = 65'(base) + 65'(len);
        if ((base % 64'(G)) != 0 || (len % 64'(G)) != 0) begin
            push(64'd0, 2'd0, 3'd0, 0, 1'b1, 1'b1, 2'd1);
        end else if (len == 0 || end_addr > (65'd1 << 64)) begin
            push(64'd0, 2'd0, 3'd0, 0, 1'b1, 1'b1, 2'd2);
        end else if (tor) begin
            push(base / 4, 2'd0, 3'd0, 0, 1'b0, 1'b0, 2'd0);
            push(64'(end_addr / 4), 2'd1, perm, 1, 1'b1, 1'b0, 2'd0);
        end else begin
            cur = 65'(base);
            rem = 65'(len);
            n   = 0;
            while (rem != 0) begin
                if (n == MAXE) begin
                    push(64'd0, 2'd0, 3'd0, n, 1'b1, 1'b1, 2'd3);
                    break;
                end
                sz = 65'd4;
                for (int k = 64; k >= 2; k--) begin
                    sz = 65'd1 << k;
                    if (sz <= rem && (cur % sz) == 0) break;
                end
                if (sz == 4)
                    push(64'(cur / 4), 2'd2, perm, n, rem == sz, 1'b0, 2'd0);
                else
                    push(64'(cur / 4 + sz / 8 - 1), 2'd3, perm, n, rem == sz, 1'b0, 2'd0);
                cur = cur + sz;
                rem = rem - sz;
                n++;
            end
        end
    endfunction

    // Issue one request and consume exp_q beats with up to max_stall stall cycles per beat.
    task automatic run_request(input logic [63:0] base, input logic [63:0] len, input logic [2:0] perm,
                               input logic tor, input int max_stall, input string name);
        int wait_cnt = 0;
        int stall;
        beat_t act;
        req_base  = base;
        req_len   = len;
        req_perm  = perm;
        req_tor   = tor;
        req_valid = 1'b1;
        while (req_ready !== 1'b1 && wait_cnt < 20) begin
            @(negedge clk);
            wait_cnt++;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s accept: req_ready=%b required 1 within 20 cycles", name, req_ready);
            req_valid = 1'b0;
            return;
        end
        @(negedge clk);
        req_valid = 1'b0;
        req_base  = {$urandom, $urandom};
        req_len   = {$urandom, $urandom};
        for (int i = 0; i < exp_q.size(); i++) begin
            stall = $urandom_range(0, max_stall);
            for (int s = 0; s <= stall; s++) begin
                entry_ready = (s == stall);
                // Requests during a sequence must be ignored.
                req_valid   = (s == stall) ? 1'b0 : 1'($urandom);
                act = observed();
                checks++;
                if (entry_valid !== 1'b1 || act !== exp_q[i]) begin
                    errors++;
                    $display("FAIL %s beat %0d cyc %0d: got valid=%b %h required valid=1 %h",
                             name, i, s, entry_valid, act, exp_q[i]);
                end
                @(negedge clk);
            end
        end
        entry_ready = 1'b0;
        req_valid   = 1'b0;
        checks++;
        if (req_ready !== 1'b1 || entry_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s idle after last: req_ready=%b entry_valid=%b required 1/0",
                     name, req_ready, entry_valid);
        end
    endtask

    task automatic test_reset();
        beat_t act;
        rst = 1'b1; req_valid = 1'b0; entry_ready = 1'b0;
        req_base = '0; req_len = '0; req_perm = '0; req_tor = 1'b0;
        repeat (3) @(negedge clk);
        act = observed();
        checks++;
        if (req_ready !== 1'b1 || entry_valid !== 1'b0 || act !== '0) begin
            errors++;
            $display("FAIL reset: ready=%b valid=%b payload=%h required 1/0/0", req_ready, entry_valid, act);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        exp_q.delete();
        push(64'h2000_01FF, 2'd3, 3'b011, 0, 1'b1, 1'b0, 2'd0);
        run_request(64'h8000_0000, 64'h1000, 3'b011, 1'b0, 3, "napot_4k");

        exp_q.delete();
`ifdef IOPMP_ENC_NA4_EN
        push(64'h401, 2'd3, 3'b101, 0, 1'b0, 1'b0, 2'd0);
        push(64'h404, 2'd3, 3'b101, 1, 1'b0, 1'b0, 2'd0);
        push(64'h406, 2'd2, 3'b101, 2, 1'b1, 1'b0, 2'd0);
`else
        push(64'h0, 2'd0, 3'd0, 0, 1'b1, 1'b1, 2'd1);
`endif
        run_request(64'h1000, 64'h1C, 3'b101, 1'b0, 3, "napot_1c");

        exp_q.delete();
`ifdef IOPMP_ENC_NA4_EN
        push(64'h401, 2'd0, 3'd0, 0, 1'b0, 1'b0, 2'd0);
        push(64'h405, 2'd1, 3'b110, 1, 1'b1, 1'b0, 2'd0);
`else
        push(64'h0, 2'd0, 3'd0, 0, 1'b1, 1'b1, 2'd1);
`endif
        run_request(64'h1004, 64'h10, 3'b110, 1'b1, 2, "tor_1004");

        exp_q.delete();
        push(64'h402, 2'd0, 3'd0, 0, 1'b0, 1'b0, 2'd0);
        push(64'h406, 2'd1, 3'b111, 1, 1'b1, 1'b0, 2'd0);
        run_request(64'h1008, 64'h10, 3'b111, 1'b1, 2, "tor_1008");

        exp_q.delete();
        push(64'h0, 2'd0, 3'd0, 0, 1'b1, 1'b1, 2'd2);
        run_request(64'h1000, 64'h0, 3'b001, 1'b0, 1, "err_len0");

        exp_q.delete();
        push(64'h0, 2'd0, 3'd0, 0, 1'b1, 1'b1, 2'd1);
        run_request(64'h1002, 64'h10, 3'b001, 1'b0, 1, "err_misalign");

        exp_q.delete();
        push(64'h0, 2'd0, 3'd0, 0, 1'b1, 1'b1, 2'd2);
        run_request(64'hFFFF_FFFF_FFFF_F000, 64'h2000, 3'b001, 1'b0, 1, "err_overflow");
    endtask

    task automatic test_boundary();
        exp_q.delete();
        push(64'h3FFF_FFFF_FFFF_FDFF, 2'd3, 3'b001, 0, 1'b1, 1'b0, 2'd0);
        run_request(64'hFFFF_FFFF_FFFF_F000, 64'h1000, 3'b001, 1'b0, 1, "top_napot");

        exp_q.delete();
        push(64'h3FFF_FFFF_FFFF_FC00, 2'd0, 3'd0, 0, 1'b0, 1'b0, 2'd0);
        push(64'h4000_0000_0000_0000, 2'd1, 3'b100, 1, 1'b1, 1'b0, 2'd0);
        run_request(64'hFFFF_FFFF_FFFF_F000, 64'h1000, 3'b100, 1'b1, 1, "top_tor");

        exp_q.delete();
        push(64'h1FF, 2'd3, 3'b010, 0, 1'b1, 1'b0, 2'd0);
        run_request(64'h0, 64'h1000, 3'b010, 1'b0, 1, "base_zero");
    endtask

    task automatic test_entry_cap();
        // 8 .. 0x80000 decomposes into exactly MAXE blocks; one more block trips the cap.
        model(64'h8, 64'h7FFF8, 3'b011, 1'b0);
        run_request(64'h8, 64'h7FFF8, 3'b011, 1'b0, 3, "cap_exact");
        model(64'h8, 64'h80000, 3'b011, 1'b0);
        run_request(64'h8, 64'h80000, 3'b011, 1'b0, 3, "cap_exceed");
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 4; r++) begin
            logic [63:0] b, l;
            b = 64'($urandom_range(0, 20'hFFFFF)) & ~64'(G - 1);
            l = 64'($urandom_range(1, 16'h3FFF)) * 64'(G);
            model(b, l, 3'b111, 1'(r % 2));
            run_request(b, l, 3'b111, 1'(r % 2), 0, "b2b");
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 80; r++) begin
            logic [63:0] b, l;
            logic [2:0]  p;
            logic        t;
            int          sel;
            b   = (64'($urandom_range(0, 20'hFFFFF)) << $urandom_range(0, 8)) & ~64'(G - 1);
            l   = 64'($urandom_range(1, 16'hFFFF)) & ~64'(G - 1);
            if (l == 0) l = 64'(G);
            p   = 3'($urandom);
            t   = ($urandom_range(0, 3) == 0);
            sel = $urandom_range(0, 11);
            case (sel)
                0: b = b | 64'(G / 2);
                1: l = l | 64'(G / 2);
                2: l = 64'd0;
                3: b = {32'hFFFF_FFFF, $urandom} & ~64'(G - 1);
                4: b = 64'd0;
                default: ;
            endcase
            model(b, l, p, t);
            run_request(b, l, p, t, 2, "random");
        end
    endtask

    task automatic test_reset_mid_stream();
        beat_t act;
        exp_q.delete();
        push(64'h401, 2'd3, 3'b101, 0, 1'b0, 1'b0, 2'd0);
        req_base = 64'h1000; req_len = 64'h18; req_perm = 3'b101; req_tor = 1'b0;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        act = observed();
        checks++;
        if (entry_valid !== 1'b1 || act !== exp_q[0]) begin
            errors++;
            $display("FAIL rst_mid first beat: got valid=%b %h required valid=1 %h", entry_valid, act, exp_q[0]);
        end
        entry_ready = 1'b1;
        @(negedge clk);
        entry_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (entry_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid after reset: valid=%b ready=%b required 0/1", entry_valid, req_ready);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (entry_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid no leftover beat: valid=%b required 0", entry_valid);
        end
        model(64'h2000, 64'h18, 3'b001, 1'b0);
        run_request(64'h2000, 64'h18, 3'b001, 1'b0, 1, "rst_mid_new");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_boundary();
        test_entry_cap();
        test_back_to_back();
        test_reset_mid_stream();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
